// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the operand-stack sequencer: value tags, stack
// interface codes, trap codes and the sequencer state type.
package stack_sequencer_pkg;

  localparam logic [1:0] TAG_I32 = 2'd0;
  localparam logic [1:0] TAG_I64 = 2'd1;
  localparam logic [1:0] TAG_F32 = 2'd2;
  localparam logic [1:0] TAG_F64 = 2'd3;

  localparam logic [1:0] STACK_NONE    = 2'd0;
  localparam logic [1:0] STACK_PUSH    = 2'd1;
  localparam logic [1:0] STACK_POP     = 2'd2;
  localparam logic [1:0] STACK_REPLACE = 2'd3;

  localparam logic [1:0] STATUS_OTHER = 2'd0;
  localparam logic [1:0] STATUS_EMPTY = 2'd1;
  localparam logic [1:0] STATUS_FULL  = 2'd2;

  localparam logic [2:0] TRAP_NONE      = 3'd0;
  localparam logic [2:0] TRAP_UNDERFLOW = 3'd1;
  localparam logic [2:0] TRAP_OVERFLOW  = 3'd2;
  localparam logic [2:0] TRAP_TYPE      = 3'd3;
  localparam logic [2:0] TRAP_ALU       = 3'd4;
  localparam logic [2:0] TRAP_ARITY     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_B,
    S_POP_B,
    S_READ_A,
    S_ALU,
    S_WB,
    S_TRAP
  } seq_state_t;

endpackage

// File: rtl/stack_sequencer.sv
// Operand-stack sequencer for multi-cycle WASM operators: pops up to two typed
// operands, runs the ALU, then pushes or replaces with the tagged result.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int TAG         = 2,
  parameter int CHECK_TYPES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_arity,
  input  logic                 req_push,
  input  logic [TAG-1:0]       req_type,
  output logic                 alu_start,
  output logic [WIDTH-1:0]     a_op,
  output logic [WIDTH-1:0]     b_op,
  input  logic                 alu_done,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [TAG-1:0]       alu_type,
  input  logic                 alu_trap,
  output logic [1:0]           stack_op,
  output logic [TAG+WIDTH-1:0] stack_data,
  input  logic [TAG+WIDTH-1:0] stack_tos,
  input  logic [1:0]           stack_status,
  output logic                 done,
  output logic [2:0]           trap
);

  seq_state_t     state;
  logic [1:0]     arity_q;
  logic           push_q;
  logic [TAG-1:0] type_q;
  logic [2:0]     tos_check;

  logic [TAG-1:0]   tos_tag;
  logic [WIDTH-1:0] tos_val;

  assign tos_tag = stack_tos[TAG+WIDTH-1:WIDTH];
  assign tos_val = stack_tos[WIDTH-1:0];

  // Shared by READ_B and READ_A: underflow takes priority over a tag mismatch.
  function automatic logic [2:0] operand_check(input logic [1:0]     status,
                                               input logic [TAG-1:0] tag,
                                               input logic [TAG-1:0] want);
    if (status == STATUS_EMPTY) return TRAP_UNDERFLOW;
    if ((CHECK_TYPES != 0) && (tag != want)) return TRAP_TYPE;
    return TRAP_NONE;
  endfunction

  always_comb tos_check = operand_check(stack_status, tos_tag, type_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      arity_q    <= 2'd0;
      push_q     <= 1'b0;
      type_q     <= '0;
      req_ready  <= 1'b0;
      alu_start  <= 1'b0;
      a_op       <= '0;
      b_op       <= '0;
      stack_op   <= STACK_NONE;
      stack_data <= '0;
      done       <= 1'b0;
      trap       <= TRAP_NONE;
    end else begin
      alu_start <= 1'b0;
      done      <= 1'b0;
      stack_op  <= STACK_NONE;
      case (state)
        S_IDLE: begin
          if (req_ready && req_valid) begin
            arity_q   <= req_arity;
            push_q    <= req_push;
            type_q    <= req_type;
            req_ready <= 1'b0;
            a_op      <= '0;
            b_op      <= '0;
            case (req_arity)
              2'd2:    state <= S_READ_B;
              2'd3: begin
                trap  <= TRAP_ARITY;
                state <= S_TRAP;
              end
              default: state <= S_READ_A;
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_READ_B: begin
          if (tos_check != TRAP_NONE) begin
            trap  <= tos_check;
            state <= S_TRAP;
          end else begin
            b_op     <= tos_val;
            stack_op <= STACK_POP;
            state    <= S_POP_B;
          end
        end
        // The stack needs a cycle after the POP before TOS shows operand a.
        S_POP_B: state <= S_READ_A;
        S_READ_A: begin
          if (arity_q != 2'd0) begin
            if (tos_check != TRAP_NONE) begin
              trap  <= tos_check;
              state <= S_TRAP;
            end else begin
              a_op      <= tos_val;
              alu_start <= 1'b1;
              state     <= S_ALU;
              if (!push_q) stack_op <= STACK_POP;
            end
          end else if (push_q && (stack_status == STATUS_FULL)) begin
            trap  <= TRAP_OVERFLOW;
            state <= S_TRAP;
          end else begin
            alu_start <= 1'b1;
            state     <= S_ALU;
          end
        end
        S_ALU: begin
          if (alu_done && !alu_start) begin
            if (alu_trap) begin
              trap  <= TRAP_ALU;
              state <= S_TRAP;
            end else begin
              stack_data <= {alu_type, alu_result};
              if (push_q) stack_op <= (arity_q == 2'd0) ? STACK_PUSH : STACK_REPLACE;
              done  <= 1'b1;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a queue-based stack environment, a delayed ALU
// responder and a rule-level reference model of each operator's outcome.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam int WIDTH = 64;
  localparam int TAG   = 2;
  localparam int DEPTH = 4;

  typedef logic [TAG+WIDTH-1:0] entry_t;

  typedef struct {
    int               trap;
    bit               start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               pops;
    int               pushes;
    int               reps;
    int               lat;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_arity;
  logic             req_push;
  logic [TAG-1:0]   req_type;
  logic             alu_start;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic [TAG-1:0]   alu_type;
  logic             alu_trap;
  logic [1:0]       stack_op;
  entry_t           stack_data;
  entry_t           stack_tos;
  logic [1:0]       stack_status;
  logic             done;
  logic [2:0]       trap;

  stack_sequencer #(.WIDTH(WIDTH), .TAG(TAG), .CHECK_TYPES(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_arity(req_arity),
    .req_push(req_push), .req_type(req_type),
    .alu_start(alu_start), .a_op(a_op), .b_op(b_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_type(alu_type), .alu_trap(alu_trap),
    .stack_op(stack_op), .stack_data(stack_data), .stack_tos(stack_tos),
    .stack_status(stack_status), .done(done), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  entry_t stk[$];
  entry_t es[$];
  logic [1:0] pend_op = STACK_NONE;
  entry_t     pend_data = '0;

  int alu_wait = 0;
  int alu_delay = 1;
  bit alu_fault = 0;
  logic [WIDTH-1:0] alu_k = '0;
  logic [TAG-1:0]   alu_tag = TAG_I32;

  int n_pop, n_push, n_rep;
  int acc_cnt, acc_cyc, done_cnt, done_cyc, done_first;
  bit seen_start;
  logic [WIDTH-1:0] seen_a, seen_b;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic updateStackOutputs();
    if (stk.size() == 0) stack_status = STATUS_EMPTY;
    else if (stk.size() == DEPTH) stack_status = STATUS_FULL;
    else stack_status = STATUS_OTHER;
    stack_tos = (stk.size() == 0) ? '0 : stk[stk.size()-1];
  endtask

  // One clock: the stack applies the op captured a cycle earlier, the ALU answers after alu_delay.
  task automatic tick();
    bit acc_now;
    acc_now = req_valid && req_ready && reset;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_now) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    case (pend_op)
      STACK_POP:     if (stk.size() > 0) void'(stk.pop_back());
      STACK_PUSH:    stk.push_back(pend_data);
      STACK_REPLACE: if (stk.size() > 0) stk[stk.size()-1] = pend_data;
      default: ;
    endcase
    pend_op   = stack_op;
    pend_data = stack_data;
    if (stack_op == STACK_POP) n_pop++;
    if (stack_op == STACK_PUSH) n_push++;
    if (stack_op == STACK_REPLACE) n_rep++;
    updateStackOutputs();
    alu_done = 1'b0;
    alu_trap = 1'b0;
    if (alu_start) begin
      alu_wait   = alu_delay;
      seen_start = 1'b1;
      seen_a     = a_op;
      seen_b     = b_op;
    end else if (alu_wait > 0) begin
      alu_wait--;
      if (alu_wait == 0) begin
        alu_done   = 1'b1;
        alu_trap   = alu_fault;
        alu_result = seen_a + seen_b + alu_k;
        alu_type   = alu_tag;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (done_cnt == 1) done_first = cyc;
    end
  endtask

  task automatic clearCounters();
    n_pop = 0; n_push = 0; n_rep = 0;
    acc_cnt = 0; acc_cyc = -1;
    done_cnt = 0; done_cyc = -1; done_first = -1;
    seen_start = 1'b0; seen_a = '0; seen_b = '0;
  endtask

  task automatic clearStack();
    stk.delete();
    es.delete();
    updateStackOutputs();
  endtask

  task automatic pushEntry(input logic [TAG-1:0] tg, input logic [WIDTH-1:0] val);
    stk.push_back({tg, val});
    es.push_back({tg, val});
    updateStackOutputs();
  endtask

  task automatic resetDut();
    reset = 1'b0;
    alu_wait = 0;
    alu_done = 1'b0;
    alu_trap = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("ready_after_reset", req_ready, 1);
  endtask

  // Reference outcome of one operator, derived from the operator rules on the expected stack.
  task automatic modelRequest(input int arity, input bit push, input logic [TAG-1:0] rtype,
                              input int delay, input bit fault, input logic [WIDTH-1:0] k,
                              input logic [TAG-1:0] rtag, output exp_t e);
    e = '{trap: 0, start: 0, a: '0, b: '0, pops: 0, pushes: 0, reps: 0,
          lat: (arity == 2 ? 4 : 2) + delay};
    if (arity == 3) begin
      e.trap = 5;
      return;
    end
    if (arity == 2) begin
      if (es.size() == 0) e.trap = 1;
      else if (es[es.size()-1][TAG+WIDTH-1:WIDTH] != rtype) e.trap = 3;
      else begin
        e.b = es[es.size()-1][WIDTH-1:0];
        void'(es.pop_back());
        e.pops++;
      end
    end
    if (e.trap == 0 && arity >= 1) begin
      if (es.size() == 0) e.trap = 1;
      else if (es[es.size()-1][TAG+WIDTH-1:WIDTH] != rtype) e.trap = 3;
      else begin
        e.a = es[es.size()-1][WIDTH-1:0];
        if (!push) begin
          void'(es.pop_back());
          e.pops++;
        end
      end
    end
    if (e.trap == 0 && arity == 0 && push && es.size() == DEPTH) e.trap = 2;
    if (e.trap != 0) return;
    e.start = 1'b1;
    if (fault) begin
      e.trap = 4;
      return;
    end
    if (push) begin
      if (arity == 0) begin
        es.push_back({rtag, e.a + e.b + k});
        e.pushes = 1;
      end else begin
        es[es.size()-1] = {rtag, e.a + e.b + k};
        e.reps = 1;
      end
    end
  endtask

  task automatic checkStack(input string name);
    check({name, "_depth"}, stk.size(), es.size());
    for (int i = 0; i < es.size() && i < stk.size(); i++)
      check({name, "_entry"}, stk[i], es[i]);
  endtask

  task automatic applyStimulus(input string name, input int arity, input bit push,
                               input logic [TAG-1:0] rtype, input int delay, input bit fault,
                               input logic [WIDTH-1:0] k, input logic [TAG-1:0] rtag);
    exp_t e;
    modelRequest(arity, push, rtype, delay, fault, k, rtag, e);
    clearCounters();
    alu_delay = delay; alu_fault = fault; alu_k = k; alu_tag = rtag;
    req_arity = 2'(arity);
    req_push  = push;
    req_type  = rtype;
    req_valid = 1'b1;
    for (int i = 0; i < 60 && done_cnt == 0 && trap == 3'd0; i++) begin
      tick();
      if (acc_cnt > 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    repeat (3) tick();
    checkOutput(name, e);
    if (trap != 3'd0 || e.trap != 0) resetDut();
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    check({name, "_trap"}, trap, e.trap);
    check({name, "_start"}, seen_start, e.start);
    if (e.start) begin
      check({name, "_a_op"}, seen_a, e.a);
      check({name, "_b_op"}, seen_b, e.b);
    end
    check({name, "_pops"}, n_pop, e.pops);
    check({name, "_pushes"}, n_push, e.pushes);
    check({name, "_replaces"}, n_rep, e.reps);
    if (e.trap == 0) begin
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_latency"}, done_cyc - acc_cyc, e.lat);
    end else begin
      check({name, "_no_done"}, done_cnt, 0);
      check({name, "_ready_low"}, req_ready, 0);
    end
    checkStack(name);
  endtask

  initial begin
    exp_t e1, e2;
    $display("[TB] stack_sequencer bench starting");
    reset = 1'b0;
    req_valid = 1'b0; req_arity = 2'd0; req_push = 1'b0; req_type = TAG_I32;
    alu_done = 1'b0; alu_result = '0; alu_type = TAG_I32; alu_trap = 1'b0;
    clearStack();
    clearCounters();
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_start", alu_start, 0);
    check("rst_stack_op", stack_op, STACK_NONE);
    check("rst_trap", trap, 0);
    check("rst_ops", {a_op, b_op}, 0);
    #20;
    reset = 1'b1;
    tick();
    tick();
    check("idle_ready", req_ready, 1);

    clearStack(); pushEntry(TAG_I32, 7); pushEntry(TAG_I32, 5);
    applyStimulus("t1_add2", 2, 1, TAG_I32, 1, 0, 0, TAG_I32);

    clearStack(); pushEntry(TAG_I64, 9);
    applyStimulus("t2_type", 1, 1, TAG_I32, 1, 0, 0, TAG_I32);

    clearStack();
    applyStimulus("t3_empty", 2, 1, TAG_I32, 1, 0, 0, TAG_I32);
    clearStack(); pushEntry(TAG_I32, 1);
    applyStimulus("t3_one", 2, 1, TAG_I32, 1, 0, 0, TAG_I32);

    clearStack();
    for (int i = 0; i < DEPTH; i++) pushEntry(TAG_I32, 64'(i + 1));
    applyStimulus("t4_full", 0, 1, TAG_I32, 1, 0, 64'h55, TAG_I32);
    clearStack(); pushEntry(TAG_F32, 3);
    applyStimulus("t4_push", 0, 1, TAG_F32, 1, 0, 64'h55, TAG_F64);

    clearStack(); pushEntry(TAG_I32, 4); pushEntry(TAG_I32, 2);
    applyStimulus("t5_alu_trap", 2, 1, TAG_I32, 4, 1, 0, TAG_I32);

    // Reset pulled low while the ALU is still busy must clear outputs asynchronously.
    clearStack(); clearCounters();
    alu_delay = 20; alu_fault = 0;
    req_arity = 2'd0; req_push = 1'b1; req_type = TAG_I32; req_valid = 1'b1;
    for (int i = 0; i < 20 && !seen_start; i++) begin
      tick();
      if (acc_cnt > 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    tick();
    check("t5_mid_alu_start_seen", seen_start, 1);
    reset = 1'b0;
    #1;
    check("t5_async_ready", req_ready, 0);
    check("t5_async_start", alu_start, 0);
    check("t5_async_done", done, 0);
    check("t5_async_op", stack_op, STACK_NONE);
    check("t5_async_data", stack_data, 0);
    check("t5_async_trap", trap, 0);
    alu_wait = 0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("t5_idle_after_release", req_ready, 1);
    check("t5_stack_untouched", stk.size(), es.size());

    // Back-to-back: {1,2,3} reduced by two adds while req_valid stays high.
    clearStack(); pushEntry(TAG_I32, 1); pushEntry(TAG_I32, 2); pushEntry(TAG_I32, 3);
    modelRequest(2, 1, TAG_I32, 1, 0, 0, TAG_I32, e1);
    modelRequest(2, 1, TAG_I32, 1, 0, 0, TAG_I32, e2);
    clearCounters();
    alu_delay = 1; alu_fault = 0; alu_k = 0; alu_tag = TAG_I32;
    req_arity = 2'd2; req_push = 1'b1; req_type = TAG_I32; req_valid = 1'b1;
    for (int i = 0; i < 80 && done_cnt < 2 && trap == 3'd0; i++) begin
      tick();
      if (acc_cnt >= 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    repeat (3) tick();
    check("t6_accepts", acc_cnt, 2);
    check("t6_dones", done_cnt, 2);
    // Done is seen after edge N; the cycle after it is IDLE, so the accept lands at edge N+2.
    check("t6_accept_gap", acc_cyc - done_first, 2);
    check("t6_latency2", done_cyc - acc_cyc, e2.lat);
    check("t6_a_op2", seen_a, e2.a);
    check("t6_b_op2", seen_b, e2.b);
    check("t6_pops", n_pop, e1.pops + e2.pops);
    check("t6_replaces", n_rep, e1.reps + e2.reps);
    check("t6_result", stk.size() == 1 ? stk[0] : '0, {TAG_I32, 64'd6});
    checkStack("t6");

    applyStimulus("t6_arity3", 3, 1, TAG_I32, 1, 0, 0, TAG_I32);

    for (int n = 0; n < 30; n++) begin
      int arity;
      if (n % 4 == 0 || stk.size() == 0) begin
        clearStack();
        for (int j = 0; j < $urandom_range(0, DEPTH); j++)
          pushEntry(2'($urandom_range(0, 1)), 64'($urandom));
      end
      arity = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      applyStimulus("rnd", arity, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                    $urandom_range(1, 3), ($urandom_range(0, 7) == 0), 64'($urandom),
                    2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
